// File: rtl/mantissa_normalize_pkg.sv
// Shared widths, state encodings and the result pack helper for the
// 12-bit FP adder post-add normaliser.
package mantissa_normalize_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 7;
  localparam int SUM_W = MAN_W + 2;
  localparam int RES_W = 1 + EXP_W + MAN_W;

  typedef logic [EXP_W-1:0] exp_t;
  typedef logic [MAN_W-1:0] man_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [RES_W-1:0] res_t;

  // All-ones exponent is reserved to mark overflow
  localparam exp_t EXP_MAX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  function automatic res_t pack_result(input logic s, input exp_t e, input man_t m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/mantissa_normalize_if.sv
// Upstream (sum/exp/sign) and downstream (packed result) valid/ready bundle.
interface mantissa_normalize_if;
  import mantissa_normalize_pkg::*;

  logic in_valid;
  logic in_ready;
  logic in_sign;
  exp_t in_exp;
  sum_t in_sum;
  logic out_valid;
  logic out_ready;
  res_t out_result;
  logic out_ovf;
  logic out_unf;

  modport master (
    output in_valid, in_sign, in_exp, in_sum, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sum, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_unf
  );

endinterface

// File: rtl/mantissa_normalize.sv
// Post-add normaliser: right shift on carry-out, otherwise left shift one bit
// per cycle until the hidden bit is set, tracking the exponent, then pack.
module mantissa_normalize
  import mantissa_normalize_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mantissa_normalize_if.slave bus
);

  logic [1:0] state;
  logic       sign_r;
  exp_t       exp_r;
  sum_t       sum_r;
  res_t       result_r;
  logic       ovf_r;
  logic       unf_r;
  exp_t       exp_inc;

  assign exp_inc = exp_r + 1'b1;

  // Accept in IDLE, walk the sum in NORM, present the result in HOLD
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      sign_r   <= 1'b0;
      exp_r    <= '0;
      sum_r    <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sign_r <= bus.in_sign;
            exp_r  <= bus.in_exp;
            sum_r  <= bus.in_sum;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            state  <= S_NORM;
          end
        end
        S_NORM: begin
          if (sum_r == '0) begin
            result_r <= '0;
            state    <= S_HOLD;
          end else if (sum_r[SUM_W-1]) begin
            sum_r <= sum_r >> 1;
            exp_r <= exp_inc;
            // A carry into the reserved exponent (or a wrap past it) overflows
            if (exp_inc == EXP_MAX || exp_r == EXP_MAX) begin
              ovf_r    <= 1'b1;
              result_r <= pack_result(sign_r, EXP_MAX, '0);
            end else begin
              result_r <= pack_result(sign_r, exp_inc, sum_r[MAN_W:1]);
            end
            state <= S_HOLD;
          end else if (sum_r[SUM_W-2]) begin
            result_r <= pack_result(sign_r, exp_r, sum_r[MAN_W-1:0]);
            state    <= S_HOLD;
          end else if (exp_r == '0) begin
            unf_r    <= 1'b1;
            result_r <= '0;
            state    <= S_HOLD;
          end else begin
            sum_r <= sum_r << 1;
            exp_r <= exp_r - 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_HOLD);
  assign bus.out_result = result_r;
  assign bus.out_ovf    = ovf_r;
  assign bus.out_unf    = unf_r;

endmodule

// File: tb/tb_mantissa_normalize.sv
// Vector table plus scoreboard bench for mantissa_normalize, with hand-written
// HOLD-stall, busy-ignore, flag-clear and mid-NORM reset sequences.
module tb_mantissa_normalize;

  typedef struct {
    logic        s;
    logic [3:0]  e;
    logic [8:0]  sum;
    logic [11:0] res;
    logic        ovf;
    logic        unf;
    int          shifts;
  } vec_t;

  typedef struct {
    logic [11:0] res;
    logic        ovf;
    logic        unf;
    int          shifts;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[12];
  sb_t  sb[$];
  int   lat;
  bit   seen;

  always #5 clk = ~clk;

  mantissa_normalize_if bus();

  mantissa_normalize dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one operand, push its expectation, and measure edges until out_valid
  task automatic applyStimulus(input vec_t v, input bit noise, output int meas);
    bit   ready_seen;
    int   c;
    sb_t  e;
    ready_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) begin
        ready_seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("in_ready_before_accept", {31'd0, ready_seen}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = v.s;
    bus.in_exp   = v.e;
    bus.in_sum   = v.sum;
    @(posedge clk);
    e.res = v.res; e.ovf = v.ovf; e.unf = v.unf; e.shifts = v.shifts;
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    c = 0;
    if (noise) begin
      bus.in_valid = 1'b1;
      bus.in_sign  = ~v.s;
      bus.in_exp   = 4'h9;
      bus.in_sum   = 9'h0C3;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      c = 1;
    end
    while (bus.out_valid !== 1'b1 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
    meas = (bus.out_valid === 1'b1) ? c : -1;
  endtask

  // Pop the scoreboard, compare, optionally stall in HOLD, then release
  task automatic checkOutput(input string tag, input int meas, input int hold);
    sb_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, ".latency"}, meas, e.shifts + 1);
    check({tag, ".result"}, {20'd0, bus.out_result}, {20'd0, e.res});
    check({tag, ".ovf"}, {31'd0, bus.out_ovf}, {31'd0, e.ovf});
    check({tag, ".unf"}, {31'd0, bus.out_unf}, {31'd0, e.unf});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, ".hold_result"}, {20'd0, bus.out_result}, {20'd0, e.res});
      check({tag, ".hold_flags"}, {30'd0, bus.out_ovf, bus.out_unf}, {30'd0, e.ovf, e.unf});
      check({tag, ".hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".released_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, ".released_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 4'h0;
    bus.in_sum    = 9'h000;
    bus.out_ready = 1'b0;

    //          s     e      sum     result  ovf   unf   shifts
    vecs[0]  = '{1'b0, 4'd5,  9'h080, 12'h280, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 4'd3,  9'h160, 12'hA30, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 4'd6,  9'h016, 12'h1B0, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b1, 4'd9,  9'h000, 12'h000, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 4'd2,  9'h004, 12'h000, 1'b0, 1'b1, 2};
    vecs[5]  = '{1'b0, 4'd14, 9'h100, 12'h780, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b1, 4'd14, 9'h1FF, 12'hF80, 1'b1, 1'b0, 0};
    vecs[7]  = '{1'b0, 4'd10, 9'h001, 12'h180, 1'b0, 1'b0, 7};
    vecs[8]  = '{1'b1, 4'd0,  9'h0FF, 12'h87F, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 4'd1,  9'h040, 12'h000, 1'b0, 1'b0, 1};
    vecs[10] = '{1'b0, 4'd3,  9'h03F, 12'h0FC, 1'b0, 1'b0, 2};
    vecs[11] = '{1'b1, 4'd7,  9'h1AB, 12'hC55, 1'b0, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset.out_result", {20'd0, bus.out_result}, 32'd0);
    check("reset.flags", {30'd0, bus.out_ovf, bus.out_unf}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], 1'b0, lat);
      checkOutput($sformatf("vec%0d", i), lat, 0);
    end

    applyStimulus(vecs[2], 1'b0, lat);
    checkOutput("hold_stall", lat, 3);

    applyStimulus(vecs[7], 1'b1, lat);
    checkOutput("busy_ignore", lat, 0);

    applyStimulus(vecs[5], 1'b0, lat);
    checkOutput("ovf_before_clear", lat, 0);

    // New accept clears the flags, then a reset one shift into NORM discards it
    bus.in_valid = 1'b1;
    bus.in_sign  = vecs[2].s;
    bus.in_exp   = vecs[2].e;
    bus.in_sum   = vecs[2].sum;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("accept.flags_cleared", {30'd0, bus.out_ovf, bus.out_unf}, 32'd0);
    check("accept.in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midreset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midreset.out_result", {20'd0, bus.out_result}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("midreset.no_output", {31'd0, seen}, 32'd0);

    applyStimulus(vecs[11], 1'b0, lat);
    checkOutput("after_reset", lat, 0);

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
